// File: rtl/pin_scan_uart_beacon_pkg.sv
// Shared state encoding, ASCII constants and message helpers for the pin-scan beacon.
// A message for pin number n is the six bytes "Pddd\r\n".
package pin_scan_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GAP    = 3'd5
    } state_e;

    localparam logic [7:0] ASCII_P  = 8'h50;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned MSG_LEN = 6;

    function automatic logic [7:0] msg_byte(input int unsigned n, input int unsigned idx);
        logic [7:0] b;
        case (idx)
            0:       b = ASCII_P;
            1:       b = ASCII_0 + 8'((n / 100) % 10);
            2:       b = ASCII_0 + 8'((n / 10) % 10);
            3:       b = ASCII_0 + 8'(n % 10);
            4:       b = ASCII_CR;
            default: b = ASCII_LF;
        endcase
        return b;
    endfunction

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/pin_scan_uart_beacon_baud_tick.sv
// Bit-period divider: emits a one-cycle tick every DIV clocks while run_i is high.
// The counter is held at zero when not running so the first period after start is full length.
module uart_baud_tick #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int unsigned           CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]      LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign tick_o = run_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pin_scan_uart_beacon.sv
// Pin-identification beacon: every tx_o[p] repeats "Pddd\r\n" (ddd = PIN_BASE+p) as UART.
// Define PIN_SCAN_PARITY_EN to send 8E1 frames instead of 8N1.
module pin_scan_uart_beacon
    import pin_scan_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25000000,
    parameter int unsigned BAUDRATE = 9600,
    parameter int unsigned NUM_PINS = 32,
    parameter int unsigned PIN_BASE = 0,
    parameter int unsigned GAP_BITS = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    output logic [NUM_PINS-1:0] tx_o,
    output logic                busy_o,
    output logic                msg_done_o,
    output logic                led_o
);

    localparam int unsigned DIV       = CLK_FREQ / BAUDRATE;
    localparam logic [2:0]  LAST_BYTE = 3'(MSG_LEN - 1);
    localparam logic [7:0]  LAST_GAP  = 8'(GAP_BITS - 1);

    state_e              state_q, state_d;
    logic [2:0]          byte_idx_q, byte_idx_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic                done_q, done_d;
    logic                busy_q;
    logic                led_q;
    logic [NUM_PINS-1:0] tx_q, tx_d;
    logic                run;
    logic                tick;

    assign run = (state_q != IDLE);

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .run_i (run),
        .tick_o(tick)
    );

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        gap_cnt_d  = gap_cnt_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef PIN_SCAN_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = GAP;
                        byte_idx_d = '0;
                        gap_cnt_d  = '0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt_q == LAST_GAP) begin
                        // enable_i is only honoured here, so a message always finishes its gap
                        state_d = enable_i ? START : IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-pin message bits are elaboration-time constants; only the shared indices select them.
    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        localparam int unsigned N    = PIN_BASE + p;
        localparam logic [47:0] BITS = {msg_byte(N, 5), msg_byte(N, 4), msg_byte(N, 3),
                                        msg_byte(N, 2), msg_byte(N, 1), msg_byte(N, 0)};
`ifdef PIN_SCAN_PARITY_EN
        localparam logic [5:0]  PAR  = {even_parity(msg_byte(N, 5)), even_parity(msg_byte(N, 4)),
                                        even_parity(msg_byte(N, 3)), even_parity(msg_byte(N, 2)),
                                        even_parity(msg_byte(N, 1)), even_parity(msg_byte(N, 0))};
        assign tx_d[p] = (state_d == START)  ? 1'b0 :
                         (state_d == DATA)   ? BITS[{byte_idx_d, bit_idx_d}] :
                         (state_d == PARITY) ? PAR[byte_idx_d] : 1'b1;
`else
        assign tx_d[p] = (state_d == START) ? 1'b0 :
                         (state_d == DATA)  ? BITS[{byte_idx_d, bit_idx_d}] : 1'b1;
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            gap_cnt_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            led_q      <= 1'b0;
            tx_q       <= '1;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            done_q     <= done_d;
            busy_q     <= (state_d != IDLE);
            led_q      <= led_q ^ done_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = busy_q;
    assign msg_done_o = done_q;
    assign led_o      = led_q;

endmodule
